mod12_count_monitor: RTL and testbench

//  Sits directly downstream of the mod-12 loadable up/down counter. Samples its count output
//  and the load/up_down controls that produced it, and classifies every step: load, up-wrap
//  (11->0), down-wrap (0->11), sequence error or range error. Keeps a signed wrap tally and

---
 rtl/count_pkg.sv | 30 +++
 rtl/mon_evt_fifo.sv | 50 +++++
 rtl/mod12_count_monitor.sv | 101 ++++++++++
 tb/tb_mod12_count_monitor.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// rtl/count_pkg.sv - shared types and constants for the mod-12 count monitor
package count_pkg;

  localparam logic [3:0] MOD12_MAX = 4'd11;

  typedef enum logic [2:0] {
    EV_NONE      = 3'd0,
    EV_LOAD      = 3'd1,
    EV_WRAP_UP   = 3'd2,
    EV_WRAP_DN   = 3'd3,
    EV_SEQ_ERR   = 3'd4,
    EV_RANGE_ERR = 3'd5
  } evt_code_e;

  typedef struct packed {
    evt_code_e  code;
    logic [3:0] cnt;
  } evt_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } mon_state_e;

  // Expected next value on a non-wrapping step; wrap cases are classified before this is used.
  function automatic logic [3:0] mod12_step(input logic [3:0] v, input logic up);
    return up ? (v + 4'd1) : (v - 4'd1);
  endfunction

endpackage

// File: rtl/mon_evt_fifo.sv
// rtl/mon_evt_fifo.sv - show-ahead event queue; a push on a full queue is taken only with a same-cycle pop
module mon_evt_fifo
  import count_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  evt_t                   i_data,
  output logic                   o_full,
  input  logic                   i_pop,
  output evt_t                   o_data,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  evt_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_level   = r_level;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
    end
  end

endmodule

// File: rtl/mod12_count_monitor.sv
// rtl/mod12_count_monitor.sv - classifies mod-12 counter steps and queues the resulting events
module mod12_count_monitor
  import count_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WRAP_W     = 8,
  parameter int DROP_W     = 8
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [3:0]                  count,
  input  logic                        load,
  input  logic                        up_down,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [2:0]                  evt_code,
  output logic [3:0]                  evt_count,
  output logic [WRAP_W-1:0]           wrap_cnt,
  output logic                        overflow,
  output logic [DROP_W-1:0]           drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  mon_state_e        r_state;
  logic [3:0]        r_prev;
  logic              r_load_q;
  logic              r_up_q;
  logic [WRAP_W-1:0] r_wrap_cnt;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_cnt;

  evt_code_e w_code;
  evt_t      w_evt;
  evt_t      w_head;
  logic      w_push;
  logic      w_pop;
  logic      w_full;
  logic      w_empty;

  // IDLE only range-checks so a stale prev after reset cannot raise LOAD or SEQ_ERR.
  always_comb begin
    w_code = EV_NONE;
    if (count > MOD12_MAX) begin
      w_code = EV_RANGE_ERR;
    end else if (r_state == ST_TRACK) begin
      if (r_load_q)                                            w_code = EV_LOAD;
      else if (r_prev > MOD12_MAX)                             w_code = EV_NONE;
      else if (r_up_q && r_prev == MOD12_MAX && count == 4'd0) w_code = EV_WRAP_UP;
      else if (!r_up_q && r_prev == 4'd0 && count == MOD12_MAX) w_code = EV_WRAP_DN;
      else if (count == mod12_step(r_prev, r_up_q))            w_code = EV_NONE;
      else                                                     w_code = EV_SEQ_ERR;
    end
  end

  assign w_evt  = '{code: w_code, cnt: count};
  assign w_push = (w_code != EV_NONE);
  assign w_pop  = evt_valid && evt_ready;

  mon_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (clock),
    .i_rst_n (resetn),
    .i_push  (w_push),
    .i_data  (w_evt),
    .o_full  (w_full),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_prev     <= '0;
      r_load_q   <= 1'b0;
      r_up_q     <= 1'b0;
      r_wrap_cnt <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state  <= ST_TRACK;
      r_prev   <= count;
      r_load_q <= load;
      r_up_q   <= up_down;
      if (w_code == EV_WRAP_UP) r_wrap_cnt <= r_wrap_cnt + WRAP_W'(1);
      if (w_code == EV_WRAP_DN) r_wrap_cnt <= r_wrap_cnt - WRAP_W'(1);
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end
    end
  end

  assign evt_valid = !w_empty;
  assign evt_code  = w_head.code;
  assign evt_count = w_head.cnt;
  assign wrap_cnt  = r_wrap_cnt;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_mod12_count_monitor.sv
// tb/tb_mod12_count_monitor.sv - directed self-checking bench for mod12_count_monitor
module tb_mod12_count_monitor;

  logic       clock = 1'b0;
  logic       resetn;
  logic [3:0] count;
  logic       load;
  logic       up_down;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_code;
  logic [3:0] evt_count;
  logic [7:0] wrap_cnt;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic [2:0] fifo_level;

  int n_checks = 0;
  int n_fail   = 0;
  int n_evt;

  mod12_count_monitor #(.FIFO_DEPTH(4), .WRAP_W(8), .DROP_W(8)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .count      (count),
    .load       (load),
    .up_down    (up_down),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_code   (evt_code),
    .evt_count  (evt_count),
    .wrap_cnt   (wrap_cnt),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .fifo_level (fifo_level)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Controls (l,u) are the ones that produce count c, so they precede c by one edge.
  task automatic step(input logic [3:0] c, input logic l, input logic u);
    load    = l;
    up_down = u;
    @(negedge clock);
    count = c;
  endtask

  task automatic do_reset();
    resetn  = 1'b0;
    count   = 4'd0;
    load    = 1'b0;
    up_down = 1'b1;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic check_head(input string tag, input logic [2:0] code, input logic [3:0] cnt);
    check({tag, "_valid"}, evt_valid, 1'b1);
    check({tag, "_code"},  evt_code,  code);
    check({tag, "_count"}, evt_count, cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    evt_ready = 1'b1;
    resetn    = 1'b0;
    count     = 4'd0;
    load      = 1'b0;
    up_down   = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_valid", evt_valid, 1'b0);
    check("rst_code",  evt_code,  3'd0);
    check("rst_count", evt_count, 4'd0);
    check("rst_wrap",  wrap_cnt,  8'd0);
    check("rst_ovf",   overflow,  1'b0);
    check("rst_drop",  drop_cnt,  8'd0);
    check("rst_level", fifo_level, 3'd0);
    resetn = 1'b1;

    // 1: up-count 0..11,0
    n_evt = 0;
    for (int i = 1; i <= 11; i++) begin
      step(4'(i), 1'b0, 1'b1);
      n_evt += int'(evt_valid);
    end
    step(4'd0, 1'b0, 1'b1);
    n_evt += int'(evt_valid);
    check("up_no_evt", n_evt, 0);
    step(4'd1, 1'b0, 1'b1);
    check_head("wrap_up", 3'd2, 4'd0);
    check("wrap_up_tally", wrap_cnt, 8'd1);
    step(4'd2, 1'b0, 1'b1);
    check("wrap_up_single", evt_valid, 1'b0);

    // 2: down-wrap from a fresh reset
    do_reset();
    step(4'd11, 1'b0, 1'b0);
    step(4'd10, 1'b0, 1'b0);
    check_head("wrap_dn", 3'd3, 4'd11);
    check("wrap_dn_tally", wrap_cnt, 8'hFF);

    // 3: load and out-of-range load
    step(4'd5, 1'b1, 1'b1);
    step(4'd6, 1'b0, 1'b1);
    check_head("load5", 3'd1, 4'd5);
    step(4'd13, 1'b1, 1'b1);
    check("after_load_quiet", evt_valid, 1'b0);
    step(4'd0, 1'b1, 1'b1);
    check_head("range13", 3'd5, 4'd13);
    step(4'd1, 1'b0, 1'b1);
    check_head("load0_after_range", 3'd1, 4'd0);

    // 4: jump and hold
    step(4'd3, 1'b1, 1'b1);
    step(4'd7, 1'b0, 1'b1);
    check_head("load3", 3'd1, 4'd3);
    step(4'd4, 1'b1, 1'b1);
    check_head("seq_jump", 3'd4, 4'd7);
    step(4'd4, 1'b0, 1'b1);
    check_head("load4", 3'd1, 4'd4);
    step(4'd5, 1'b0, 1'b1);
    check_head("seq_hold", 3'd4, 4'd4);
    step(4'd6, 1'b0, 1'b1);
    check("legal_quiet", evt_valid, 1'b0);

    // 5: overflow with six events against a stalled consumer
    evt_ready = 1'b0;
    for (int i = 0; i <= 5; i++) step(4'(i), 1'b1, 1'b1);
    step(4'd6, 1'b0, 1'b1);
    check("full_level", fifo_level, 3'd4);
    check("full_ovf",   overflow,   1'b1);
    check("full_drop",  drop_cnt,   8'd2);
    check_head("full_head", 3'd1, 4'd0);
    evt_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(4'(6 + i), 1'b0, 1'b1);
      check_head($sformatf("drain%0d", i), 3'd1, 4'(i));
    end
    step(4'd10, 1'b0, 1'b1);
    check("drained_valid", evt_valid, 1'b0);
    check("drained_level", fifo_level, 3'd0);
    check("drained_code",  evt_code,   3'd0);
    check("drained_count", evt_count,  4'd0);

    // full + push + pop in the same cycle
    evt_ready = 1'b0;
    for (int i = 0; i <= 4; i++) step(4'(i), 1'b1, 1'b1);
    check("refill_level", fifo_level, 3'd4);
    evt_ready = 1'b1;
    step(4'd5, 1'b0, 1'b1);
    check("pushpop_level", fifo_level, 3'd4);
    check("pushpop_drop",  drop_cnt,   8'd2);
    check_head("pushpop_head", 3'd1, 4'd1);

    // 6: reset mid-drain
    step(4'd6, 1'b0, 1'b1);
    check("middrain_level", fifo_level, 3'd3);
    #2 resetn = 1'b0;
    #1;
    check("midrst_valid", evt_valid, 1'b0);
    check("midrst_wrap",  wrap_cnt,  8'd0);
    check("midrst_ovf",   overflow,  1'b0);
    check("midrst_drop",  drop_cnt,  8'd0);
    check("midrst_level", fifo_level, 3'd0);
    count   = 4'd9;
    load    = 1'b0;
    up_down = 1'b1;
    @(negedge clock);
    resetn = 1'b1;
    step(4'd10, 1'b0, 1'b1);
    check("post_rst_idle", evt_valid, 1'b0);
    step(4'd11, 1'b0, 1'b1);
    check("post_rst_track", evt_valid, 1'b0);
    check("post_rst_level", fifo_level, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
